// File: rtl/hex_number_overlay.sv
// hex_number_overlay
//   Draws a NUM_DIGITS-digit hexadecimal value as a text box in the off-grid
//   area of the VGA screen. The value is latched once per frame into a shadow
//   register so a frame never shows a mix of old and new digits. Two-stage
//   pipeline: pixel coordinates in -> request/colour out two clocks later.
//
// Ports
//   CLK_50                 system clock
//   reset                  synchronous, active-high
//   pixel_x / pixel_y      current VGA column / row (10 bit)
//   value                  live value, 4*NUM_DIGITS bits, digit 0 = MS nibble
//   hold                   1 = keep the displayed value frozen
//   number_drawing_request pixel lies inside the text box
//   number_rgb             RRRGGGBB colour for the pixel (0 outside the box)
module hex_number_overlay #(
  parameter int         NUM_DIGITS = 8,
  parameter int         X_POS      = 528,
  parameter int         Y_POS      = 400,
  parameter int         SCALE_BITS = 1,
  parameter logic [7:0] FG_RGB     = 8'hFF,
  parameter logic [7:0] BG_RGB     = 8'h02
) (
  input  logic                    CLK_50,
  input  logic                    reset,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    hold,
  output logic                    number_drawing_request,
  output logic [7:0]              number_rgb
);
  localparam int          VW    = 4 * NUM_DIGITS;
  localparam logic [31:0] X0    = 32'(X_POS);
  localparam logic [31:0] Y0    = 32'(Y_POS);
  localparam logic [31:0] BOX_W = 32'((NUM_DIGITS * 8) << SCALE_BITS);
  localparam logic [31:0] BOX_H = 32'(8 << SCALE_BITS);

  // 5x7 glyph rows, row 0 in the top 5 bits, MSB of each row = leftmost column
  function automatic logic [4:0] glyph_row(input logic [3:0] nib, input logic [2:0] row);
    logic [34:0] g;
    case (nib)
      4'h0: g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'h1: g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'h2: g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'h3: g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'h4: g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'h5: g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'h6: g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'h7: g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'h8: g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'h9: g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      4'hA: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
      4'hB: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      4'hC: g = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      4'hD: g = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      4'hE: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      default: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
    endcase
    // row 7 is the inter-line spacing row
    glyph_row = (row == 3'd7) ? 5'h00 : g[34 - 5*int'(row) -: 5];
  endfunction

  // frame capture
  logic [VW-1:0] shadow_q, shadow_d;
  logic [9:0]    prev_y_q;
  logic          frame_start;

  assign frame_start = (pixel_y == 10'd0) && (prev_y_q != 10'd0);
  assign shadow_d    = (frame_start && !hold) ? value : shadow_q;

  // stage 1: box test and glyph addressing (32-bit so the box end never wraps)
  logic [31:0] px, py, dx, dy;
  logic        in_box_d, in_box_s1_q;
  logic [3:0]  nib_d, nib_s1_q;
  logic [2:0]  col_d, col_s1_q, row_d, row_s1_q;

  always_comb begin
    px       = 32'(pixel_x);
    py       = 32'(pixel_y);
    in_box_d = (px >= X0) && (px < X0 + BOX_W) && (py >= Y0) && (py < Y0 + BOX_H);
    dx       = (px - X0) >> SCALE_BITS;
    dy       = (py - Y0) >> SCALE_BITS;
    col_d    = dx[2:0];
    row_d    = dy[2:0];
    // digit select by compare keeps the index in range when outside the box
    nib_d    = 4'h0;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (dx[31:3] == 29'(d)) nib_d = shadow_q[4*(NUM_DIGITS-1-d) +: 4];
  end

  // stage 2: pixel colour. Padding the 5-bit row to 8 bits makes cols 5..7 clear.
  logic [7:0] row_bits;
  logic       pix_on;
  logic       req_q, req_d;
  logic [7:0] rgb_q, rgb_d;

  always_comb begin
    row_bits = {glyph_row(nib_s1_q, row_s1_q), 3'b000};
    pix_on   = row_bits[3'd7 - col_s1_q];
    req_d    = in_box_s1_q;
    rgb_d    = in_box_s1_q ? (pix_on ? FG_RGB : BG_RGB) : 8'h00;
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      shadow_q    <= '0;
      prev_y_q    <= '0;
      in_box_s1_q <= 1'b0;
      nib_s1_q    <= '0;
      col_s1_q    <= '0;
      row_s1_q    <= '0;
      req_q       <= 1'b0;
      rgb_q       <= 8'h00;
    end else begin
      shadow_q    <= shadow_d;
      prev_y_q    <= pixel_y;
      in_box_s1_q <= in_box_d;
      nib_s1_q    <= nib_d;
      col_s1_q    <= col_d;
      row_s1_q    <= row_d;
      req_q       <= req_d;
      rgb_q       <= rgb_d;
    end
  end

  assign number_drawing_request = req_q;
  assign number_rgb             = rgb_q;
endmodule

// File: tb/tb_hex_number_overlay.sv
module tb_hex_number_overlay;
  localparam int ND = 8, XP = 528, YP = 400, SB = 1;
  localparam int S  = 1 << SB;
  localparam logic [7:0] FG = 8'hFF, BG = 8'h02;

  logic        CLK_50 = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic [31:0] value;
  logic        hold;
  logic        number_drawing_request;
  logic [7:0]  number_rgb;

  hex_number_overlay #(.NUM_DIGITS(ND), .X_POS(XP), .Y_POS(YP), .SCALE_BITS(SB),
                       .FG_RGB(FG), .BG_RGB(BG)) dut (
    .CLK_50(CLK_50), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .value(value), .hold(hold),
    .number_drawing_request(number_drawing_request), .number_rgb(number_rgb));

  always #10 CLK_50 = ~CLK_50;

  typedef struct packed { logic req; logic [7:0] rgb; } pix_t;

  // reference font: 7 rows per glyph, 5 bits per row, leftmost pixel = bit 4
  int font [16][7] = '{
    '{'h0E,'h11,'h13,'h15,'h19,'h11,'h0E}, '{'h04,'h0C,'h04,'h04,'h04,'h04,'h0E},
    '{'h0E,'h11,'h01,'h02,'h04,'h08,'h1F}, '{'h1F,'h02,'h04,'h02,'h01,'h11,'h0E},
    '{'h02,'h06,'h0A,'h12,'h1F,'h02,'h02}, '{'h1F,'h10,'h1E,'h01,'h01,'h11,'h0E},
    '{'h06,'h08,'h10,'h1E,'h11,'h11,'h0E}, '{'h1F,'h01,'h02,'h04,'h08,'h08,'h08},
    '{'h0E,'h11,'h11,'h0E,'h11,'h11,'h0E}, '{'h0E,'h11,'h11,'h0F,'h01,'h02,'h0C},
    '{'h0E,'h11,'h11,'h11,'h1F,'h11,'h11}, '{'h1E,'h11,'h11,'h1E,'h11,'h11,'h1E},
    '{'h0E,'h11,'h10,'h10,'h10,'h11,'h0E}, '{'h1C,'h12,'h11,'h11,'h11,'h12,'h1C},
    '{'h1F,'h10,'h10,'h1E,'h10,'h10,'h1F}, '{'h1F,'h10,'h10,'h1E,'h10,'h10,'h10}};

  int          n_cmp = 0, n_err = 0;
  logic [31:0] mshadow;
  int          mprev;
  pix_t        expq[$];

  function automatic pix_t model(input int x, input int y, input logic [31:0] sh);
    pix_t r;
    int fx, fy, digit, col, row, nib;
    r = '0;
    if (x >= XP && x < XP + ND*8*S && y >= YP && y < YP + 8*S) begin
      fx    = (x - XP) / S;
      fy    = (y - YP) / S;
      digit = fx / 8;
      col   = fx % 8;
      row   = fy % 8;
      nib   = int'((sh >> (4*(ND-1-digit))) & 32'hF);
      r.req = 1'b1;
      r.rgb = (col < 5 && row < 7 && ((font[nib][row] >> (4-col)) & 1) == 1) ? FG : BG;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock with the given pixel; checks against the model every cycle
  task automatic step(input int x, input int y, input logic r);
    pix_t e, want;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    reset   = r;
    e = model(x, y, mshadow);
    @(posedge CLK_50);
    if (r) begin
      mshadow = '0;
      mprev   = 0;
      expq.delete();
      expq.push_back('0);
      want = '0;
    end else begin
      if (y == 0 && mprev != 0 && !hold) mshadow = value;
      mprev = y;
      want  = (expq.size() > 0) ? expq.pop_front() : '0;
      expq.push_back(e);
    end
    #1;
    chk("model_req", 8'(number_drawing_request), 8'(want.req));
    chk("model_rgb", number_rgb, want.rgb);
  endtask

  // hold one pixel long enough for it to reach the outputs
  task automatic at(input int x, input int y);
    step(x, y, 1'b0);
    step(x, y, 1'b0);
  endtask

  task automatic frame_start();
    step(479, 479, 1'b0);
    step(0, 0, 1'b0);
  endtask

  initial begin
    mshadow = '0; mprev = 0;
    value = 32'h0; hold = 1'b0; reset = 1'b1;
    pixel_x = 10'(XP); pixel_y = 10'(YP);

    // 1: reset with pixel inside the box
    for (int i = 0; i < 3; i++) begin
      step(XP, YP, 1'b1);
      chk("rst_req", 8'(number_drawing_request), 8'd0);
      chk("rst_rgb", number_rgb, 8'h00);
    end
    step(XP, YP, 1'b0);
    chk("rel1_req", 8'(number_drawing_request), 8'd0);
    step(XP, YP, 1'b0);
    chk("rel2_req", 8'(number_drawing_request), 8'd1);
    chk("rel2_rgb", number_rgb, BG);

    // 2: '0' glyph
    value = 32'h0000_0000;
    frame_start();
    at(528, 400); chk("zero_c0", number_rgb, BG);
    at(530, 400); chk("zero_c1", number_rgb, FG);

    // 3: 'F' top row
    value = 32'hF000_0000;
    frame_start();
    for (int x = 528; x <= 537; x++) begin
      at(x, 400); chk("F_row0", number_rgb, FG);
    end
    at(538, 400); chk("F_col5", number_rgb, BG);

    // 4: hold
    hold = 1'b1; value = 32'h1111_1111;
    frame_start();
    at(528, 400); chk("hold_F", number_rgb, FG);
    hold = 1'b0;
    frame_start();
    at(532, 400); chk("one_c2", number_rgb, FG);
    at(528, 400); chk("one_c0", number_rgb, BG);

    // 5: box edges
    at(527, 400); chk("x527", 8'(number_drawing_request), 8'd0);
    at(655, 400); chk("x655", 8'(number_drawing_request), 8'd1);
    at(656, 400); chk("x656", 8'(number_drawing_request), 8'd0);
    at(600, 415); chk("y415", 8'(number_drawing_request), 8'd1);
    at(600, 416); chk("y416", 8'(number_drawing_request), 8'd0);
    at(600, 399); chk("y399", 8'(number_drawing_request), 8'd0);

    // 6: value change on the frame_start cycle is captured, one later is not
    value = 32'h1000_0000;
    step(479, 479, 1'b0);
    value = 32'hF000_0000;
    step(0, 0, 1'b0);
    value = 32'h0000_0000;
    step(0, 1, 1'b0);
    at(528, 400); chk("same_cyc", number_rgb, FG);
    frame_start();
    at(528, 400); chk("next_frm", number_rgb, BG);

    // mid-frame reset clears the shadow
    value = 32'hFFFF_FFFF;
    frame_start();
    at(528, 400); chk("pre_rst", number_rgb, FG);
    step(528, 400, 1'b1);
    chk("midrst_req", 8'(number_drawing_request), 8'd0);
    at(528, 400); chk("post_rst", number_rgb, BG);

    // random scan against the model
    for (int i = 0; i < 4000; i++) begin
      int x, y, k;
      k = int'($urandom_range(0, 99));
      if (k < 5)       y = 0;
      else if (k < 60) y = int'($urandom_range(395, 420));
      else             y = int'($urandom_range(0, 524));
      x = (k % 3 == 0) ? int'($urandom_range(0, 799)) : int'($urandom_range(520, 665));
      value = $urandom();
      hold  = ($urandom_range(0, 3) == 0);
      step(x, y, $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
